// File: rtl/saved_reg_bank.sv
// saved_reg_bank: x0/x9/x18..x27 register storage fed by one-hot write enables, with two bypassing read ports
module saved_reg_bank #(
    parameter int XLEN   = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            enrx00,
    input  logic            enrx09,
    input  logic            enrx18,
    input  logic            enrx19,
    input  logic            enrx20,
    input  logic            enrx21,
    input  logic            enrx22,
    input  logic            enrx23,
    input  logic            enrx24,
    input  logic            enrx25,
    input  logic            enrx26,
    input  logic            enrx27,
    input  logic [XLEN-1:0] wr_data,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            onehot_err,
    output logic [7:0]      wr_count
);
    logic [11:0]     en;
    logic            multi;
    logic            commit;
    logic [3:0]      i1;
    logic [3:0]      i2;
    logic [XLEN-1:0] regs_q [12];
    logic [XLEN-1:0] regs_d [12];
    logic            err_q;
    logic            err_d;
    logic [7:0]      cnt_q;
    logic [7:0]      cnt_d;

    function automatic logic [3:0] reg_idx(input logic [4:0] a);
        return (a == 5'd9) ? 4'd1 : (a >= 5'd18 && a <= 5'd27) ? 4'(a - 5'd16) : 4'd0;
    endfunction

    // Slot 0 stands for x0 and every unsupported address; it is never written.
    assign en     = {enrx27, enrx26, enrx25, enrx24, enrx23, enrx22, enrx21, enrx20, enrx19, enrx18, enrx09, enrx00};
    assign multi  = |(en & (en - 12'd1));
    assign commit = wr_en && !multi && |en[11:1];
    assign i1     = reg_idx(rs1_addr);
    assign i2     = reg_idx(rs2_addr);

    assign rs1_data   = (BYPASS != 0 && commit && i1 != 4'd0 && en[i1]) ? wr_data : regs_q[i1];
    assign rs2_data   = (BYPASS != 0 && commit && i2 != 4'd0 && en[i2]) ? wr_data : regs_q[i2];
    assign onehot_err = err_q;
    assign wr_count   = cnt_q;

    always_comb begin
        regs_d[0] = '0;
        for (int k = 1; k < 12; k++) regs_d[k] = (commit && en[k]) ? wr_data : regs_q[k];
        err_d = err_q || (wr_en && multi);
        cnt_d = cnt_q + 8'(commit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 12; k++) regs_q[k] <= '0;
            err_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            for (int k = 0; k < 12; k++) regs_q[k] <= regs_d[k];
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end
endmodule
